boot_seq: RTL
=============

BOOT_SEQ -- requirements
Module: boot_seq

Interface
REQ-001 Parameter DRAIN_CYCLES, default 5, SHALL set the number of cycles the pipeline is held cleared after boot completes (legal 1-15).
REQ-002 Parameter HALT_ADDR, default 16'hFFFF, SHALL set the peripheral address whose write halts the core.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 boot_up  input  1  high while the host is loading the instruction cache.
REQ-006 boot_web  input  1  active-low host write strobe, valid only while boot_up=1.
REQ-007 boot_addr  input  8  host instruction-cache word address.
REQ-008 boot_datai  input  32  host instruction word.
REQ-009 peri_web  input  1  active-low core peripheral write strobe.
REQ-010 peri_addr  input  16  core peripheral write address.
REQ-011 icache_web  output  1  registered active-low instruction-cache write strobe.
REQ-012 icache_addr  output  8  registered instruction-cache write address.
REQ-013 icache_datai  output  32  registered instruction-cache write data.
REQ-014 pc_run  output  1  high = PC and pipeline are released (drives the pipeline's system reset gating).
REQ-015 pc_clear  output  1  one-cycle pulse that zeroes the PC.
REQ-016 halted  output  1  high while in HALT.
REQ-017 boot_err  output  1  sticky flag: a boot ended with zero words written.
REQ-018 word_cnt  output  9  words written in the current or last boot, 0-256.
REQ-019 run_cycles  output  32  cycles spent in RUN since the last boot, saturating.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, LOAD, DRAIN, RUN, HALT.
REQ-021 IDLE: pc_run=0; boot_up=1 -> LOAD.
REQ-022 LOAD entry SHALL clear word_cnt, run_cycles and boot_err.
REQ-023 In LOAD, each cycle with boot_web=0 SHALL register one write to icache_* with one cycle of latency and increment word_cnt, saturating at 256.
REQ-024 icache_web SHALL be 1 in every state other than LOAD, and on every LOAD cycle with boot_web=1; boot_web=0 while boot_up=0 SHALL be ignored.
REQ-025 Repeated writes to the same boot_addr SHALL each be forwarded and counted.
REQ-026 LOAD with boot_up=0 and word_cnt>0 -> DRAIN; LOAD with boot_up=0 and word_cnt=0 -> IDLE with boot_err=1.
REQ-027 A write on the same cycle boot_up falls SHALL be ignored.
REQ-028 DRAIN SHALL assert pc_clear on its first cycle only, hold pc_run=0 for exactly DRAIN_CYCLES cycles using a 4-bit down-counter, then go to RUN.
REQ-029 RUN: pc_run=1; run_cycles SHALL increment by 1 per cycle and saturate at 32'hFFFFFFFF.
REQ-030 RUN with peri_web=0 and peri_addr=HALT_ADDR -> HALT; pc_run SHALL be 0 from the next cycle.
REQ-031 HALT: pc_run=0, halted=1, run_cycles frozen; boot_up=1 -> LOAD.
REQ-032 boot_up=1 in DRAIN or RUN SHALL go to LOAD on the next edge (reboot) and SHALL take priority over a simultaneous halt write.
REQ-033 peri writes outside RUN SHALL have no effect.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, icache_web=1, icache_addr=0, icache_datai=0, pc_run=0, pc_clear=0, halted=0, boot_err=0, word_cnt=0, run_cycles=0 and the DRAIN counter to 0.
REQ-035 rst asserted mid-LOAD or mid-DRAIN SHALL abandon the sequence; after release, boot_up=1 starts a fresh LOAD.

Verification
REQ-036 Boot of 4 words (addr 0-3, data 32'h11111111+i), boot_up falls -> 4 icache writes 1 cycle late, word_cnt=4, pc_clear pulse, pc_run=1 exactly 5 cycles after DRAIN entry.
REQ-037 Run 100 cycles, then peri_web=0, peri_addr=16'hFFFF -> halted=1, pc_run=0 next cycle, run_cycles=101 and frozen.
REQ-038 boot_up pulses 3 cycles with boot_web=1 throughout -> returns to IDLE, boot_err=1, pc_run stays 0.
REQ-039 boot_up=1 during RUN, same cycle as a halt write -> LOAD entered, halted=0, word_cnt=0, run_cycles=0.
REQ-040 Reset asserted asynchronously mid-LOAD after 2 writes -> all outputs at reset values without waiting for a clock edge; no further icache writes.
REQ-041 260 boot writes -> word_cnt saturates at 256; all 260 writes reach the icache.

Source files
------------

// File: rtl/boot_seq.sv
// Boot sequencer: forwards host instruction-cache loads, then drains the
// pipeline, releases the core and halts it on a write to HALT_ADDR.
module boot_seq #(
  parameter int unsigned DRAIN_CYCLES = 5,        // legal range 1-15
  parameter logic [15:0] HALT_ADDR    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_up,
  input  logic        boot_web,
  input  logic [7:0]  boot_addr,
  input  logic [31:0] boot_datai,
  input  logic        peri_web,
  input  logic [15:0] peri_addr,
  output logic        icache_web,
  output logic [7:0]  icache_addr,
  output logic [31:0] icache_datai,
  output logic        pc_run,
  output logic        pc_clear,
  output logic        halted,
  output logic        boot_err,
  output logic [8:0]  word_cnt,
  output logic [31:0] run_cycles
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 9;
  localparam int unsigned RUN_W  = 32;

  localparam logic [WORD_W-1:0] WORD_MAX   = WORD_W'(256);
  localparam logic [RUN_W-1:0]  RUN_MAX    = {RUN_W{1'b1}};
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   drain_cnt;
  logic [CNT_W-1:0]   drain_cnt_nxt;
  logic               icache_web_nxt;
  logic [ADDR_W-1:0]  icache_addr_nxt;
  logic [DATA_W-1:0]  icache_datai_nxt;
  logic               pc_run_nxt;
  logic               pc_clear_nxt;
  logic               halted_nxt;
  logic               boot_err_nxt;
  logic [WORD_W-1:0]  word_cnt_nxt;
  logic [RUN_W-1:0]   run_cycles_nxt;
  logic               halt_hit;
  logic               load_start;

  // State register plus every registered output; reset is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      drain_cnt    <= '0;
      icache_web   <= 1'b1;
      icache_addr  <= '0;
      icache_datai <= '0;
      pc_run       <= 1'b0;
      pc_clear     <= 1'b0;
      halted       <= 1'b0;
      boot_err     <= 1'b0;
      word_cnt     <= '0;
      run_cycles   <= '0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      icache_web   <= icache_web_nxt;
      icache_addr  <= icache_addr_nxt;
      icache_datai <= icache_datai_nxt;
      pc_run       <= pc_run_nxt;
      pc_clear     <= pc_clear_nxt;
      halted       <= halted_nxt;
      boot_err     <= boot_err_nxt;
      word_cnt     <= word_cnt_nxt;
      run_cycles   <= run_cycles_nxt;
    end
  end

  // Next state and next output values; outputs describe the state being entered.
  always_comb begin
    state_nxt        = state;
    drain_cnt_nxt    = '0;
    icache_web_nxt   = 1'b1;
    icache_addr_nxt  = icache_addr;
    icache_datai_nxt = icache_datai;
    pc_run_nxt       = 1'b0;
    pc_clear_nxt     = 1'b0;
    halted_nxt       = 1'b0;
    boot_err_nxt     = boot_err;
    word_cnt_nxt     = word_cnt;
    run_cycles_nxt   = run_cycles;
    load_start       = 1'b0;
    halt_hit         = !peri_web && (peri_addr == HALT_ADDR);

    case (state)
      S_IDLE: begin
        if (boot_up) begin
          load_start = 1'b1;
        end
      end

      S_LOAD: begin
        if (!boot_up) begin
          // A strobe on the falling cycle of boot_up is dropped.
          if (word_cnt != '0) begin
            state_nxt     = S_DRAIN;
            pc_clear_nxt  = 1'b1;
            drain_cnt_nxt = DRAIN_LOAD;
          end else begin
            state_nxt    = S_IDLE;
            boot_err_nxt = 1'b1;
          end
        end else if (!boot_web) begin
          icache_web_nxt   = 1'b0;
          icache_addr_nxt  = boot_addr;
          icache_datai_nxt = boot_datai;
          if (word_cnt != WORD_MAX) begin
            word_cnt_nxt = word_cnt + WORD_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (boot_up) begin
          load_start = 1'b1;
        end else if (drain_cnt <= CNT_W'(1)) begin
          state_nxt  = S_RUN;
          pc_run_nxt = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end

      S_RUN: begin
        if (run_cycles != RUN_MAX) begin
          run_cycles_nxt = run_cycles + RUN_W'(1);
        end
        // Reboot wins over a simultaneous halt write.
        if (boot_up) begin
          load_start = 1'b1;
        end else if (halt_hit) begin
          state_nxt  = S_HALT;
          halted_nxt = 1'b1;
        end else begin
          pc_run_nxt = 1'b1;
        end
      end

      S_HALT: begin
        halted_nxt = 1'b1;
        if (boot_up) begin
          load_start = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Common LOAD entry: fresh counters and cleared error for the new boot.
    if (load_start) begin
      state_nxt      = S_LOAD;
      drain_cnt_nxt  = '0;
      word_cnt_nxt   = '0;
      run_cycles_nxt = '0;
      boot_err_nxt   = 1'b0;
      halted_nxt     = 1'b0;
      pc_run_nxt     = 1'b0;
      pc_clear_nxt   = 1'b0;
    end
  end

endmodule
